// File: rtl/seq_mult_shift_add.sv
// Sequential radix-2 shift/add multiplier: WIDTH x WIDTH -> 2*WIDTH, one partial product per cycle.
// Signed operands are handled as sign-magnitude around an unsigned core.
module seq_mult_shift_add #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Product_o,
  output logic [1:0]         state_o
);

  // Handshake: start is sampled only in IDLE or DONE; the edge that samples it latches
  // A/B/signed_i and enters RUN (busy=1). After WIDTH edges done pulses for one cycle
  // with Product_o new; start held during DONE begins the next operation on that edge.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               sgn;
  logic [WIDTH-1:0]   mag_a, mag_b, addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_step, mplr_step;
  logic [2*WIDTH-1:0] mag_prod;

  always_comb begin
    sgn    = SIGNED_EN && signed_i;
    // |-2^(W-1)| wraps to 2^(W-1), which is still correct read as unsigned.
    mag_a  = (sgn && A[WIDTH-1]) ? -A : A;
    mag_b  = (sgn && B[WIDTH-1]) ? -B : B;

    addend    = mplr_q[0] ? mcand_q : '0;
    sum       = {1'b0, acc_q} + {1'b0, addend};
    acc_step  = sum[WIDTH:1];
    mplr_step = {sum[0], mplr_q[WIDTH-1:1]};
    mag_prod  = {acc_step, mplr_step};

    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    neg_d   = neg_q;
    prod_d  = prod_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          mcand_d = mag_a;
          mplr_d  = mag_b;
          acc_d   = '0;
          neg_d   = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d  = acc_step;
        mplr_d = mplr_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          prod_d  = neg_q ? -mag_prod : mag_prod;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign Product_o = prod_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Bench for seq_mult_shift_add (WIDTH=8, SIGNED_EN=1): directed vectors feed an expected
// queue; a negedge monitor pops and compares at every done pulse.
module tb_seq_mult_shift_add;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_i;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        busy;
  logic        done;
  logic [15:0] Product_o;
  logic [1:0]  state_o;

  logic [15:0] exp_q[$];
  int          st_q[$];
  int          n_vec  = 0;
  int          n_err  = 0;
  int          n_acc  = 0;
  int          n_done = 0;
  int          cyc    = 0;

  seq_mult_shift_add #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_i  (signed_i),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .Product_o (Product_o),
    .state_o   (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'h00, a};
    eb = s ? {{8{b[7]}}, b} : {8'h00, b};
    return ea * eb;
  endfunction

  // scoreboard monitor
  logic [15:0] mon_exp;
  int          mon_st;
  always @(negedge clk) begin
    if (rst) begin
      check("busy_done_excl", 32'(busy & done), 32'd0);
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_st  = st_q.pop_front();
          check("product", 32'(Product_o), 32'(mon_exp));
          check("latency", 32'(cyc - mon_st), 32'd8);
        end
      end
    end
  end

  // driver: caller is at a negedge; returns at the negedge where done is seen
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp);
    int nb;
    bit seen;
    A = a; B = b; signed_i = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back(exp);
    st_q.push_back(cyc);
    n_acc++;
    check("busy_after_start", 32'(busy), 32'd1);
    A = $urandom_range(0, 255);
    B = $urandom_range(0, 255);
    signed_i = $urandom_range(0, 1);
    nb = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) seen = 1;
    end
    check("done_timeout", 32'(seen), 32'd1);
    check("busy_cycles", 32'(nb), 32'd8);
  endtask

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int t1, t2, ndone_win;
    bit seen;
    logic [7:0] ra, rb;
    logic rs;

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
    vecs[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[3]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
    vecs[4]  = '{8'h00, 8'hA7, 1'b0, 16'h0000};
    vecs[5]  = '{8'h01, 8'hA7, 1'b1, 16'hFFA7};
    vecs[6]  = '{8'hFD, 8'hFD, 1'b1, 16'h0009};
    vecs[7]  = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    vecs[8]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    vecs[9]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    vecs[10] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[11] = '{8'h80, 8'h01, 1'b1, 16'hFF80};
    vecs[12] = '{8'h0F, 8'h10, 1'b0, 16'h00F0};
    vecs[13] = '{8'hFD, 8'h05, 1'b0, 16'h04F1};

    rst = 1'b0; start = 1'b0; signed_i = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(Product_o), 32'd0);
    check("reset_state", 32'(state_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // directed table, with an idle cycle between some ops and back-to-back for others
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p);
      if (i % 2 == 1) @(negedge clk);
    end

    // start held through RUN: operands change to 7,7 while busy and must be ignored
    @(negedge clk);
    A = 8'd2; B = 8'd3; signed_i = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(16'd6);
    st_q.push_back(cyc);
    n_acc++;
    @(negedge clk);
    A = 8'd7; B = 8'd7;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("held_first_done", 32'(seen), 32'd1);
    t1 = cyc;
    exp_q.push_back(16'd49);
    st_q.push_back(cyc + 1);
    n_acc++;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_done_drop", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_product_hold", 32'(Product_o), 32'd6);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("held_second_done", 32'(seen), 32'd1);
    t2 = cyc;
    check("done_spacing", 32'(t2 - t1), 32'd9);

    // reset in the fourth RUN cycle discards the operation
    @(negedge clk);
    A = 8'd9; B = 8'd9; signed_i = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_product", 32'(Product_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ndone_win = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) ndone_win++;
    end
    check("no_done_after_rst", 32'(ndone_win), 32'd0);

    run_op(8'hFD, 8'h05, 1'b1, 16'hFFF1);

    // random operands with random gaps, checked against the reference multiply
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, ref_mul(ra, rb, rs));
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_vs_accepted", 32'(n_done), 32'(n_acc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
